// File: rtl/interval_envelope_detector.sv
// Per-interval envelope detector: peak-to-peak amplitude of each (min, max) pair,
// hysteresis onset/offset events with a hold count, and frame peak tracking.
module interval_envelope_detector #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16,
  parameter int HOLD   = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_min,
  input  logic signed [DATA_W-1:0] in_max,
  input  logic                     in_last,
  input  logic [DATA_W:0]          thr_on,
  input  logic [DATA_W:0]          thr_off,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W:0]          out_p2p,
  output logic [CNT_W-1:0]         out_index,
  output logic [1:0]               out_event,
  output logic                     out_active,
  output logic                     out_last,
  output logic [DATA_W:0]          peak_p2p,
  output logic [CNT_W-1:0]         peak_index,
  output logic                     err,
  output logic                     done
);

  localparam int QW = (HOLD < 1) ? 1 : $clog2(HOLD + 1);

  localparam logic [1:0] EV_NONE   = 2'b00;
  localparam logic [1:0] EV_ONSET  = 2'b01;
  localparam logic [1:0] EV_OFFSET = 2'b10;

  typedef enum logic [1:0] {IDLE, WAIT_IN, EVAL, EMIT} state_t;

  state_t state, next_state;

  logic [CNT_W-1:0]  index;
  logic              active;
  logic [QW-1:0]     quiet_cnt;
  logic [DATA_W:0]   p2p_q;
  logic              last_q;

  logic [DATA_W:0]   diff;
  logic              malformed;
  logic              eval_active;
  logic [QW-1:0]     eval_quiet;
  logic [QW-1:0]     quiet_inc;
  logic [1:0]        eval_event;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE:    if (start) next_state = WAIT_IN;
      WAIT_IN: begin
        in_ready = 1'b1;
        if (in_valid) next_state = EVAL;
      end
      EVAL:    next_state = EMIT;
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready) next_state = out_last ? IDLE : WAIT_IN;
      end
      default: next_state = IDLE;
    endcase
  end

  // Sign-extend both operands by one bit so the full signed span fits unsigned.
  always_comb begin
    diff      = {in_max[DATA_W-1], in_max} - {in_min[DATA_W-1], in_min};
    malformed = (in_min > in_max);
  end

  always_comb begin
    eval_active = active;
    eval_quiet  = quiet_cnt;
    eval_event  = EV_NONE;
    quiet_inc   = quiet_cnt + 1'b1;
    if (!active) begin
      if (p2p_q >= thr_on) begin
        eval_active = 1'b1;
        eval_event  = EV_ONSET;
        eval_quiet  = '0;
      end
    end else if (p2p_q < thr_off) begin
      if (quiet_inc == QW'(HOLD)) begin
        eval_active = 1'b0;
        eval_event  = EV_OFFSET;
        eval_quiet  = '0;
      end else begin
        eval_quiet = quiet_inc;
      end
    end else begin
      eval_quiet = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      index      <= '0;
      active     <= 1'b0;
      quiet_cnt  <= '0;
      p2p_q      <= '0;
      last_q     <= 1'b0;
      out_p2p    <= '0;
      out_index  <= '0;
      out_event  <= EV_NONE;
      out_active <= 1'b0;
      out_last   <= 1'b0;
      peak_p2p   <= '0;
      peak_index <= '0;
      err        <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            index      <= '0;
            active     <= 1'b0;
            quiet_cnt  <= '0;
            peak_p2p   <= '0;
            peak_index <= '0;
            err        <= 1'b0;
            done       <= 1'b0;
          end
        end
        WAIT_IN: begin
          if (in_valid) begin
            p2p_q  <= malformed ? '0 : diff;
            last_q <= in_last;
            if (malformed) err <= 1'b1;
          end
        end
        EVAL: begin
          active     <= eval_active;
          quiet_cnt  <= eval_quiet;
          out_p2p    <= p2p_q;
          out_index  <= index;
          out_event  <= eval_event;
          out_active <= eval_active;
          out_last   <= last_q;
          // Strict compare keeps the earliest interval on ties.
          if (p2p_q > peak_p2p) begin
            peak_p2p   <= p2p_q;
            peak_index <= index;
          end
        end
        EMIT: begin
          if (out_ready) begin
            index <= index + 1'b1;
            if (out_last) done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
